fifo_rr_arbiter: RTL

Four-input round-robin arbiter that drains the 8x12b virtual-channel FIFOs and forwards one 12-bit word per cycle into a single downstream FIFO. Sits directly downstream of the four VC FIFOs, driving their `pop` inputs from their `empty` flags. Applies back-pressure from the downstream FIFO's `alm_full`. Keeps a running count of forwarded words for the bench and the control FSM.

---
 rtl/fifo_rr_arbiter_pkg.sv | 26 ++
 rtl/fifo_rr_arbiter_picker.sv | 30 +++
 rtl/fifo_rr_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared constants, FSM encoding and helpers for the VC FIFO round-robin arbiter.
package fifo_rr_arbiter_pkg;

  localparam int DATA_W = 12;
  localparam int N_IN   = 4;
  localparam int IDX_W  = 2;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  // Encoding of the control FSM state whose decode drives the arbiter enable.
  localparam logic [3:0] CTRL_ACTIVE = 4'd3;

  function automatic logic ctrl_enable(input logic [3:0] ctrl_state);
    return (ctrl_state == CTRL_ACTIVE);
  endfunction

  function automatic logic [N_IN-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return {{(N_IN-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_picker.sv
// Combinational round-robin picker: first eligible requester after `last`, wrapping.
module rr_priority_picker
  import fifo_rr_arbiter_pkg::*;
(
  input  logic [N_IN-1:0]  eligible,
  input  logic [IDX_W-1:0] last,
  output logic [N_IN-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // Walk last+1 .. last+4 (mod 4); the first eligible candidate wins.
  always_comb begin
    grant_idx = {IDX_W{1'b0}};
    any       = 1'b0;
    cand_s    = {IDX_W{1'b0}};
    hit_s     = 1'b0;
    for (int k = 1; k <= N_IN; k++) begin
      cand_s    = last + IDX_W'(k);
      hit_s     = !any && eligible[cand_s];
      grant_idx = hit_s ? cand_s : grant_idx;
      any       = any | hit_s;
    end
    grant = any ? idx_to_onehot(grant_idx) : {N_IN{1'b0}};
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Drains four VC FIFOs round-robin into one downstream FIFO, one word per cycle,
// with a pop -> mux -> push pipeline and a running count of forwarded words.
module fifo_rr_arbiter
  import fifo_rr_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [N_IN-1:0]        empty_in,
  input  logic [N_IN*DATA_W-1:0] data_in,
  input  logic                   alm_full_out,
  output logic [N_IN-1:0]        pop,
  output logic                   push_out,
  output logic [DATA_W-1:0]      data_out,
  output logic [IDX_W-1:0]       grant_id,
  output logic [CNT_W-1:0]       word_count
);

  arb_state_e        state_r;
  arb_state_e        state_nxt_s;
  logic [IDX_W-1:0]  last_r;
  logic [N_IN-1:0]   popped_r;
  logic [N_IN-1:0]   eligible_s;
  logic [N_IN-1:0]   grant_s;
  logic [IDX_W-1:0]  grant_idx_s;
  logic              any_s;
  logic              pop_en_s;
  logic              v1_r;
  logic [IDX_W-1:0]  gid1_r;
  logic              push_r;
  logic [DATA_W-1:0] data_r;
  logic [IDX_W-1:0]  grant_id_r;
  logic [CNT_W-1:0]  word_count_r;
  logic [DATA_W-1:0] word_s;

  // A FIFO popped last cycle still shows stale non-empty; mask it for one cycle.
  assign eligible_s = ~empty_in & ~popped_r;

  rr_priority_picker u_picker (
    .eligible  (eligible_s),
    .last      (last_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any       (any_s)
  );

  // Next-state decode and pop qualification (enable gates the pop combinationally).
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = enable ? RUN : IDLE;
      RUN:     state_nxt_s = enable ? RUN : DRAIN;
      DRAIN:   state_nxt_s = enable ? RUN : ((v1_r || push_r) ? DRAIN : IDLE);
      default: state_nxt_s = IDLE;
    endcase
    pop_en_s = (state_r == RUN) && enable && !alm_full_out && any_s;
  end

  assign pop    = pop_en_s ? grant_s : {N_IN{1'b0}};
  assign word_s = data_in[int'(gid1_r) * DATA_W +: DATA_W];

  // FSM state, round-robin pointer and pop-mask registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      last_r   <= 2'd3;
      popped_r <= 4'b0000;
    end else begin
      state_r  <= state_nxt_s;
      last_r   <= pop_en_s ? grant_idx_s : last_r;
      popped_r <= pop;
    end
  end

  // Two-stage data pipeline; the count advances in step with push_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_r         <= 1'b0;
      gid1_r       <= 2'd0;
      push_r       <= 1'b0;
      data_r       <= 12'h000;
      grant_id_r   <= 2'd0;
      word_count_r <= 16'h0000;
    end else begin
      v1_r   <= pop_en_s;
      gid1_r <= pop_en_s ? grant_idx_s : gid1_r;
      push_r <= v1_r;
      if (v1_r) begin
        data_r       <= word_s;
        grant_id_r   <= gid1_r;
        word_count_r <= word_count_r + 16'd1;
      end else begin
        data_r       <= data_r;
        grant_id_r   <= grant_id_r;
        word_count_r <= word_count_r;
      end
    end
  end

  assign push_out   = push_r;
  assign data_out   = data_r;
  assign grant_id   = grant_id_r;
  assign word_count = word_count_r;

endmodule
